mfilter_config_ctrl: RTL and testbench

MFILTER_CONFIG_CTRL -- requirements
Module: mfilter_config_ctrl

---
 rtl/mfilter_config_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mfilter_config_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfilter_config_ctrl.sv
// Matched-filter configuration controller: shadow/active register double buffer,
// commit-by-swap sequencing, match acknowledge and holdoff-gated match counting.
module mfilter_config_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_strobe,
  input  logic [6:0]   serial_addr,
  input  logic [31:0]  serial_data,
  input  logic         rxstrobe,
  input  logic         match,
  output logic [383:0] co_bank,
  output logic [7:0]   co_length,
  output logic         co_valid,
  output logic [31:0]  threshhold,
  output logic         ack,
  output logic         match_event,
  output logic [15:0]  match_count,
  output logic [7:0]   status
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;
  localparam logic [1:0] ST_SWAP    = 2'd3;

  localparam logic [6:0] ADDR_LEN  = 7'd12;
  localparam logic [6:0] ADDR_THR  = 7'd13;
  localparam logic [6:0] ADDR_CTRL = 7'd14;
  localparam logic [6:0] ADDR_HOLD = 7'd15;
  localparam logic [7:0] MAX_LEN   = 8'd192;

  logic [11:0][31:0] shadow_coef_r, active_coef_r;
  logic [7:0]        shadow_len_r, active_len_r;
  logic [31:0]       shadow_thr_r, active_thr_r;
  logic [15:0]       holdoff_r, hcnt_r, hcnt_nxt_s;
  logic [15:0]       match_count_r, match_count_nxt_s;
  logic [1:0]        state_r, state_nxt_s;
  logic              enable_r, committed_r, shadow_dirty_r, err_r;
  logic              co_valid_r, ack_r, match_event_r;
  logic              ctrl_wr_s, shadow_wr_s, enable_s, len_ok_s;
  logic              commit_ok_s, commit_bad_s, clear_s, ack_s, count_s;

  // Register-write decode and match qualification.
  always_comb begin
    ctrl_wr_s    = serial_strobe && (serial_addr == ADDR_CTRL);
    shadow_wr_s  = serial_strobe && ((serial_addr < ADDR_CTRL) || (serial_addr == ADDR_HOLD));
    if (ctrl_wr_s) begin
      enable_s = serial_data[0];
    end else begin
      enable_s = enable_r;
    end
    len_ok_s     = (shadow_len_r != 8'd0) && (shadow_len_r <= MAX_LEN);
    commit_ok_s  = ctrl_wr_s && serial_data[1] && len_ok_s;
    commit_bad_s = ctrl_wr_s && serial_data[1] && !len_ok_s;
    clear_s      = ctrl_wr_s && serial_data[2];
    // A held match line is acknowledged every other cycle.
    ack_s        = match && !ack_r;
    count_s      = ack_s && (state_r == ST_RUN) && !commit_ok_s;
  end

  // Next state, holdoff counter and match counter.
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
    if (commit_ok_s) begin
      state_nxt_s = ST_SWAP;
      hcnt_nxt_s  = 16'd0;
    end else if (ctrl_wr_s && !serial_data[0]) begin
      state_nxt_s = ST_IDLE;
      hcnt_nxt_s  = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable_s && committed_r) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (count_s) begin
            hcnt_nxt_s = holdoff_r;
            if (holdoff_r != 16'd0) begin
              state_nxt_s = ST_HOLDOFF;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HOLDOFF: begin
          if (rxstrobe) begin
            hcnt_nxt_s = hcnt_r - 16'd1;
            if (hcnt_r <= 16'd1) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_HOLDOFF;
            end
          end else begin
            state_nxt_s = ST_HOLDOFF;
          end
        end
        ST_SWAP: begin
          if (enable_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          hcnt_nxt_s  = 16'd0;
        end
      endcase
    end

    if (clear_s) begin
      if (count_s) begin
        match_count_nxt_s = 16'd1;
      end else begin
        match_count_nxt_s = 16'd0;
      end
    end else if (count_s && (match_count_r != 16'hFFFF)) begin
      match_count_nxt_s = match_count_r + 16'd1;
    end else begin
      match_count_nxt_s = match_count_r;
    end
  end

  // Shadow register file and host-visible control bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_coef_r  <= '0;
      shadow_len_r   <= 8'd0;
      shadow_thr_r   <= 32'd0;
      holdoff_r      <= 16'd0;
      enable_r       <= 1'b0;
      shadow_dirty_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      if (serial_strobe && (serial_addr < ADDR_LEN)) begin
        shadow_coef_r[serial_addr[3:0]] <= serial_data;
      end
      if (serial_strobe && (serial_addr == ADDR_LEN)) begin
        shadow_len_r <= serial_data[7:0];
      end
      if (serial_strobe && (serial_addr == ADDR_THR)) begin
        shadow_thr_r <= serial_data;
      end
      if (serial_strobe && (serial_addr == ADDR_HOLD)) begin
        holdoff_r <= serial_data[15:0];
      end
      enable_r <= enable_s;
      // A write landing during SWAP keeps the shadow dirty.
      if (shadow_wr_s) begin
        shadow_dirty_r <= 1'b1;
      end else if (state_r == ST_SWAP) begin
        shadow_dirty_r <= 1'b0;
      end
      if (commit_bad_s) begin
        err_r <= 1'b1;
      end else if (state_r == ST_SWAP) begin
        err_r <= 1'b0;
      end
    end
  end

  // Active configuration, state machine and match outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_coef_r <= '0;
      active_len_r  <= 8'd0;
      active_thr_r  <= 32'd0;
      committed_r   <= 1'b0;
      state_r       <= ST_IDLE;
      hcnt_r        <= 16'd0;
      co_valid_r    <= 1'b0;
      ack_r         <= 1'b0;
      match_event_r <= 1'b0;
      match_count_r <= 16'd0;
    end else begin
      if (state_r == ST_SWAP) begin
        active_coef_r <= shadow_coef_r;
        active_len_r  <= shadow_len_r;
        active_thr_r  <= shadow_thr_r;
        committed_r   <= 1'b1;
      end
      state_r       <= state_nxt_s;
      hcnt_r        <= hcnt_nxt_s;
      co_valid_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_HOLDOFF);
      ack_r         <= ack_s;
      match_event_r <= count_s;
      match_count_r <= match_count_nxt_s;
    end
  end

  assign co_bank     = active_coef_r;
  assign co_length   = active_len_r;
  assign threshhold  = active_thr_r;
  assign co_valid    = co_valid_r;
  assign ack         = ack_r;
  assign match_event = match_event_r;
  assign match_count = match_count_r;
  assign status      = {state_r, err_r, shadow_dirty_r, 4'b0000};

endmodule

// File: tb/tb_mfilter_config_ctrl.sv
// Self-checking bench for mfilter_config_ctrl: directed vector table, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_mfilter_config_ctrl;
  logic         clk, reset, serial_strobe, rxstrobe, match;
  logic [6:0]   serial_addr;
  logic [31:0]  serial_data;
  logic [383:0] co_bank;
  logic [7:0]   co_length, status;
  logic         co_valid, ack, match_event;
  logic [31:0]  threshhold;
  logic [15:0]  match_count;

  int n_total = 0;
  int n_pass  = 0;

  localparam int IDLE = 0, RUN = 1, HOLDOFF = 2, SWAP = 3;

  mfilter_config_ctrl dut (
    .clk(clk), .reset(reset), .serial_strobe(serial_strobe), .serial_addr(serial_addr),
    .serial_data(serial_data), .rxstrobe(rxstrobe), .match(match), .co_bank(co_bank),
    .co_length(co_length), .co_valid(co_valid), .threshhold(threshhold), .ack(ack),
    .match_event(match_event), .match_count(match_count), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_sh_coef [12];
  logic [31:0] m_act_coef [12];
  logic [7:0]  m_sh_len, m_act_len;
  logic [31:0] m_sh_thr, m_act_thr;
  logic [15:0] m_hold;
  int          m_hleft, m_mode, m_cnt;
  bit          m_en, m_dirty, m_err, m_once, m_ack, m_evt, m_valid;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_sh_coef[i] = 32'd0;
      m_act_coef[i] = 32'd0;
    end
    m_sh_len = 8'd0; m_act_len = 8'd0; m_sh_thr = 32'd0; m_act_thr = 32'd0;
    m_hold = 16'd0; m_hleft = 0; m_mode = IDLE; m_cnt = 0;
    m_en = 0; m_dirty = 0; m_err = 0; m_once = 0; m_ack = 0; m_evt = 0; m_valid = 0;
  endtask

  task automatic model_step();
    bit wr_ctrl, new_en, good, bad, acked, counted, clr;
    int nmode;
    if (reset) begin
      model_reset();
    end else begin
      wr_ctrl = serial_strobe && (serial_addr == 7'd14);
      new_en  = wr_ctrl ? serial_data[0] : m_en;
      good    = wr_ctrl && serial_data[1] && (m_sh_len >= 8'd1) && (m_sh_len <= 8'd192);
      bad     = wr_ctrl && serial_data[1] && !good;
      clr     = wr_ctrl && serial_data[2];
      acked   = match && !m_ack;
      counted = acked && (m_mode == RUN) && !good;
      nmode   = m_mode;
      if (good) nmode = SWAP;
      else if (wr_ctrl && !serial_data[0]) nmode = IDLE;
      else if (m_mode == SWAP) nmode = new_en ? RUN : IDLE;
      else if (m_mode == IDLE) begin
        if (new_en && m_once) nmode = RUN;
      end else if (counted) begin
        m_hleft = int'(m_hold);
        if (m_hold > 16'd0) nmode = HOLDOFF;
      end else if (m_mode == HOLDOFF && rxstrobe) begin
        m_hleft = m_hleft - 1;
        if (m_hleft == 0) nmode = RUN;
      end
      if (m_mode == SWAP) begin
        for (int i = 0; i < 12; i++) m_act_coef[i] = m_sh_coef[i];
        m_act_len = m_sh_len; m_act_thr = m_sh_thr;
        m_once = 1; m_dirty = 0; m_err = 0;
      end
      if (bad) m_err = 1;
      if (serial_strobe) begin
        if (serial_addr < 7'd12) m_sh_coef[serial_addr] = serial_data;
        else if (serial_addr == 7'd12) m_sh_len = serial_data[7:0];
        else if (serial_addr == 7'd13) m_sh_thr = serial_data;
        else if (serial_addr == 7'd15) m_hold = serial_data[15:0];
        if (serial_addr <= 7'd13 || serial_addr == 7'd15) m_dirty = 1;
      end
      if (clr) m_cnt = counted ? 1 : 0;
      else if (counted && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_ack = acked; m_evt = counted; m_en = new_en; m_mode = nmode;
      m_valid = (nmode == RUN) || (nmode == HOLDOFF);
    end
  endtask

  task automatic check_model();
    logic [383:0] eb;
    logic [1:0]   ms;
    for (int i = 0; i < 12; i++) eb[i*32 +: 32] = m_act_coef[i];
    ms = m_mode[1:0];
    chk("co_bank", co_bank, eb);
    chk("co_length", 384'(co_length), 384'(m_act_len));
    chk("threshhold", 384'(threshhold), 384'(m_act_thr));
    chk("co_valid", 384'(co_valid), 384'(m_valid));
    chk("ack", 384'(ack), 384'(m_ack));
    chk("match_event", 384'(match_event), 384'(m_evt));
    chk("match_count", 384'(match_count), 384'(m_cnt[15:0]));
    chk("status", 384'(status), 384'({ms, m_err, m_dirty, 4'b0000}));
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_in();
    serial_strobe = 1'b0; serial_addr = 7'd0; serial_data = 32'd0;
    rxstrobe = 1'b0; match = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    idle_in();
    serial_strobe = 1'b1; serial_addr = a; serial_data = d;
    tick();
  endtask

  typedef struct {
    logic        strobe;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        rx;
    logic        mt;
    logic [1:0]  st;
    logic        valid;
    logic        ak;
    logic        ev;
    logic [15:0] cnt;
    logic        er;
    logic [7:0]  len;
  } vec_t;

  function automatic vec_t v(logic s, logic [6:0] a, logic [31:0] d, logic r, logic m,
                             logic [1:0] st, logic vl, logic ak, logic ev, logic [15:0] c,
                             logic er, logic [7:0] ln);
    vec_t t;
    t.strobe = s; t.addr = a; t.data = d; t.rx = r; t.mt = m;
    t.st = st; t.valid = vl; t.ak = ak; t.ev = ev; t.cnt = c; t.er = er; t.len = ln;
    return t;
  endfunction

  vec_t vecs [17];

  initial begin
    // strobe addr data rx match | state valid ack event count err length
    vecs[0]  = v(1, 14, 3,   0, 0, 3, 0, 0, 0, 0, 0, 0);
    vecs[1]  = v(0, 0,  0,   0, 0, 1, 1, 0, 0, 0, 0, 96);
    vecs[2]  = v(1, 15, 3,   0, 0, 1, 1, 0, 0, 0, 0, 96);
    vecs[3]  = v(0, 0,  0,   0, 1, 2, 1, 1, 1, 1, 0, 96);
    vecs[4]  = v(0, 0,  0,   0, 1, 2, 1, 0, 0, 1, 0, 96);
    vecs[5]  = v(0, 0,  0,   1, 1, 2, 1, 1, 0, 1, 0, 96);
    vecs[6]  = v(0, 0,  0,   1, 1, 2, 1, 0, 0, 1, 0, 96);
    vecs[7]  = v(0, 0,  0,   1, 1, 1, 1, 1, 0, 1, 0, 96);
    vecs[8]  = v(0, 0,  0,   0, 1, 1, 1, 0, 0, 1, 0, 96);
    vecs[9]  = v(0, 0,  0,   0, 1, 2, 1, 1, 1, 2, 0, 96);
    vecs[10] = v(1, 14, 0,   0, 0, 0, 0, 0, 0, 2, 0, 96);
    vecs[11] = v(1, 14, 1,   0, 0, 1, 1, 0, 0, 2, 0, 96);
    vecs[12] = v(1, 12, 0,   0, 0, 1, 1, 0, 0, 2, 0, 96);
    vecs[13] = v(1, 14, 3,   0, 0, 1, 1, 0, 0, 2, 1, 96);
    vecs[14] = v(1, 12, 200, 0, 0, 1, 1, 0, 0, 2, 1, 96);
    vecs[15] = v(1, 14, 3,   0, 0, 1, 1, 0, 0, 2, 1, 96);
    vecs[16] = v(1, 14, 5,   0, 0, 1, 1, 0, 0, 0, 1, 96);

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_status", 384'(status), 384'(8'h00));
    chk("rst_valid", 384'(co_valid), 384'(1'b0));
    chk("rst_count", 384'(match_count), 384'(16'h0000));

    // Load the shadow set: nothing active may move before a commit.
    for (int i = 0; i < 12; i++) wr(7'(i), 32'hA5A5A5A5 + 32'(i));
    wr(7'd12, 32'd96);
    wr(7'd13, 32'h1000);
    chk("pre_commit_len", 384'(co_length), 384'(8'd0));
    chk("pre_commit_dirty", 384'(status[4]), 384'(1'b1));

    for (int i = 0; i < 17; i++) begin
      idle_in();
      serial_strobe = vecs[i].strobe; serial_addr = vecs[i].addr; serial_data = vecs[i].data;
      rxstrobe = vecs[i].rx; match = vecs[i].mt;
      tick();
      chk($sformatf("vec%0d_state", i), 384'(status[7:6]), 384'(vecs[i].st));
      chk($sformatf("vec%0d_valid", i), 384'(co_valid), 384'(vecs[i].valid));
      chk($sformatf("vec%0d_ack", i), 384'(ack), 384'(vecs[i].ak));
      chk($sformatf("vec%0d_event", i), 384'(match_event), 384'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 384'(match_count), 384'(vecs[i].cnt));
      chk($sformatf("vec%0d_err", i), 384'(status[5]), 384'(vecs[i].er));
      chk($sformatf("vec%0d_len", i), 384'(co_length), 384'(vecs[i].len));
    end
    for (int i = 0; i < 12; i++)
      chk($sformatf("bank_word%0d", i), 384'(co_bank[i*32 +: 32]), 384'(32'hA5A5A5A5 + 32'(i)));
    chk("bank_thresh", 384'(threshhold), 384'(32'h1000));

    // Saturation: preload the counter to its ceiling.
    wr(7'd15, 32'd0);
    idle_in();
    force dut.match_count_r = 16'hFFFF;
    m_cnt = 65535;
    tick();
    release dut.match_count_r;
    match = 1'b1;
    tick();
    chk("sat_count", 384'(match_count), 384'(16'hFFFF));
    chk("sat_event", 384'(match_event), 384'(1'b1));
    idle_in();
    tick();
    serial_strobe = 1'b1; serial_addr = 7'd14; serial_data = 32'h5; match = 1'b1;
    tick();
    chk("clear_with_match", 384'(match_count), 384'(16'd1));

    // Commit during HOLDOFF with a simultaneous match, then a write during SWAP.
    wr(7'd12, 32'd50);
    wr(7'd15, 32'd2);
    idle_in(); match = 1'b1;
    tick();
    chk("ho_state", 384'(status[7:6]), 384'(2'd2));
    idle_in();
    tick();
    serial_strobe = 1'b1; serial_addr = 7'd14; serial_data = 32'h3; match = 1'b1;
    tick();
    chk("abort_state", 384'(status[7:6]), 384'(2'd3));
    chk("abort_ack", 384'(ack), 384'(1'b1));
    chk("abort_event", 384'(match_event), 384'(1'b0));
    wr(7'd0, 32'hDEADBEEF);
    chk("swap_word0", 384'(co_bank[31:0]), 384'(32'hA5A5A5A5));
    chk("swap_len", 384'(co_length), 384'(8'd50));
    chk("swap_dirty", 384'(status[4]), 384'(1'b1));

    // Reset mid-HOLDOFF, then enable without any commit.
    idle_in(); match = 1'b1;
    tick();
    chk("pre_rst_state", 384'(status[7:6]), 384'(2'd2));
    idle_in(); reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_bank", co_bank, 384'd0);
    chk("rst2_status", 384'(status), 384'(8'h00));
    chk("rst2_misc", 384'({co_valid, ack, match_event, match_count, co_length, threshhold}), 384'd0);
    wr(7'd14, 32'h1);
    chk("no_commit_idle", 384'(status[7:6]), 384'(2'd0));
    chk("no_commit_valid", 384'(co_valid), 384'(1'b0));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      idle_in();
      reset = ($urandom_range(0, 199) == 0);
      rxstrobe = $urandom_range(0, 1) == 1;
      match = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) begin
        serial_strobe = 1'b1;
        serial_addr = 7'($urandom_range(0, 17));
        case (serial_addr)
          7'd12: serial_data = 32'($urandom_range(0, 255));
          7'd14: serial_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7))
                                                             : 32'($urandom_range(0, 3) | 1);
          7'd15: serial_data = 32'($urandom_range(0, 4));
          default: serial_data = $urandom;
        endcase
      end
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
